// File: rtl/dac_write_spi_if.sv
// Interface for the DAC write SPI block: the sample request inputs and the
// SPI, latch and status outputs. The requester (the master) drives the
// request side; the block (the slave) drives everything else.
interface dac_write_spi_if;
    logic        start;
    logic [11:0] data_in;
    logic        gain_1x;
    logic        buf_en;
    logic        shutdown;
    logic        sck_out;
    logic        mosi;
    logic        cs_n;
    logic        ldac_n;
    logic        busy;
    logic        done;

    modport master (
        output start, data_in, gain_1x, buf_en, shutdown,
        input  sck_out, mosi, cs_n, ldac_n, busy, done
    );

    modport slave (
        input  start, data_in, gain_1x, buf_en, shutdown,
        output sck_out, mosi, cs_n, ldac_n, busy, done
    );
endinterface

// File: rtl/dac_write_spi.sv
// Single-channel DAC writer: sends one 16-bit command word (channel A,
// buffer, gain, shutdown, 12-bit code) MSB first in SPI mode 0, then pulses
// ldac_n to move the word to the DAC output. Every output is a flop.
module dac_write_spi #(
    parameter int HALF_DIV = 4
) (
    input  logic           clk,
    input  logic           reset,
    dac_write_spi_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] LATCH = 2'd3;

    localparam logic [7:0] DIV_LAST = 8'(HALF_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'd15;

    logic [1:0]  state;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [15:0] frame;
    logic [15:0] load_word;
    logic        div_end;

    logic sck_q;
    logic mosi_q;
    logic cs_n_q;
    logic ldac_n_q;
    logic busy_q;
    logic done_q;

    // Command word assembled from the request inputs: channel A, buffer,
    // gain, active-high output enable, then the code.
    assign load_word = {1'b0, bus.buf_en, bus.gain_1x, ~bus.shutdown, bus.data_in};
    assign div_end   = (div_cnt == DIV_LAST);

    // Sequencer: frame timing, serial shift and latch strobe.
    // NOTE: all state here uses non-blocking assignments so every flop
    // samples pre-edge values and the block behaves as parallel registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            // NOTE: the frame register is a plain flop bank, so it is cleared
            // with everything else; no stale word survives an aborted frame.
            frame    <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            ldac_n_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        frame   <= load_word;
                        mosi_q  <= load_word[15];
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        // First rising edge; pre-shift so the top bit is the
                        // one to present at the coming falling edge.
                        sck_q   <= 1'b1;
                        frame   <= {frame[14:0], 1'b0};
                        div_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (sck_q) begin
                            // End of high phase: fall, and present the next
                            // bit unless this was the last one.
                            sck_q <= 1'b0;
                            if (bit_cnt != BIT_LAST) begin
                                mosi_q <= frame[15];
                            end
                        end else if (bit_cnt == BIT_LAST) begin
                            // Low phase of bit 16 was the CS hold time.
                            cs_n_q   <= 1'b1;
                            ldac_n_q <= 1'b0;
                            state    <= LATCH;
                        end else begin
                            sck_q   <= 1'b1;
                            frame   <= {frame[14:0], 1'b0};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                LATCH: begin
                    if (div_end) begin
                        ldac_n_q <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        mosi_q   <= 1'b0;
                        div_cnt  <= '0;
                        state    <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sck_out = sck_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.ldac_n  = ldac_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_dac_write_spi.sv
// Bench for dac_write_spi: two instances (HALF_DIV=4 and HALF_DIV=1) share
// the request inputs; sel chooses which one receives start and is observed.
// An SPI slave model captures bits on sck_out rises and measures the frame
// timeline against the expected cycle numbers.
module tb_dac_write_spi;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sel;
    logic [11:0] data_in;
    logic        gain_1x;
    logic        buf_en;
    logic        shutdown;

    int checks = 0;
    int errors = 0;

    dac_write_spi_if if4 ();
    dac_write_spi_if if1 ();

    assign if4.start    = start & ~sel;
    assign if1.start    = start & sel;
    assign if4.data_in  = data_in;
    assign if1.data_in  = data_in;
    assign if4.gain_1x  = gain_1x;
    assign if1.gain_1x  = gain_1x;
    assign if4.buf_en   = buf_en;
    assign if1.buf_en   = buf_en;
    assign if4.shutdown = shutdown;
    assign if1.shutdown = shutdown;

    dac_write_spi #(.HALF_DIV(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));
    dac_write_spi #(.HALF_DIV(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    // Observed instance outputs.
    logic o_sck, o_mosi, o_cs_n, o_ldac_n, o_busy, o_done;
    assign o_sck    = sel ? if1.sck_out : if4.sck_out;
    assign o_mosi   = sel ? if1.mosi    : if4.mosi;
    assign o_cs_n   = sel ? if1.cs_n    : if4.cs_n;
    assign o_ldac_n = sel ? if1.ldac_n  : if4.ldac_n;
    assign o_busy   = sel ? if1.busy    : if4.busy;
    assign o_done   = sel ? if1.done    : if4.done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the command word from the field rules.
    function automatic logic [15:0] exp_frame(input logic [11:0] d, input logic g,
                                              input logic b, input logic s);
        return {1'b0, b, g, ~s, d};
    endfunction

    // Protocol properties on both instances, every cycle.
    logic [1:0] w_sck, w_mosi, w_cs_n, w_ldac_n, w_done;
    logic [1:0] prev_mosi = '0;
    logic [1:0] prev_done = '0;
    assign w_sck    = {if1.sck_out, if4.sck_out};
    assign w_mosi   = {if1.mosi,    if4.mosi};
    assign w_cs_n   = {if1.cs_n,    if4.cs_n};
    assign w_ldac_n = {if1.ldac_n,  if4.ldac_n};
    assign w_done   = {if1.done,    if4.done};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_sck[i] === 1'b1)    check("mosi_stable_sck_high", w_mosi[i], prev_mosi[i]);
            if (w_cs_n[i] === 1'b1)   check("sck_low_cs_high", w_sck[i], 1'b0);
            if (w_ldac_n[i] === 1'b0) check("ldac_only_cs_high", w_cs_n[i], 1'b1);
            if (prev_done[i] === 1'b1) check("done_one_cycle", w_done[i], 1'b0);
        end
        prev_mosi <= w_mosi;
        prev_done <= w_done;
    end

    // Measurements of one frame, cycle k = period after acceptance edge k-1.
    logic [15:0] m_frame;
    int m_rises, m_rises_cs_high, m_first_rise;
    int m_cs_first, m_cs_last, m_cs_cnt;
    int m_ldac_first, m_ldac_last, m_ldac_cnt;
    int m_done_cyc;

    // Caller has start=1 and fields set before the acceptance edge.
    task automatic run_frame(input bit hold, input int inject_at, input bit scramble,
                             input logic [11:0] nd, input logic ng, input logic nb,
                             input logic ns);
        int  h;
        int  limit;
        logic prev_sck;
        h = sel ? 1 : 4;
        limit = 34 * h + 9;
        m_frame = '0; m_rises = 0; m_rises_cs_high = 0; m_first_rise = -1;
        m_cs_first = -1; m_cs_last = -1; m_cs_cnt = 0;
        m_ldac_first = -1; m_ldac_last = -1; m_ldac_cnt = 0; m_done_cyc = -1;
        prev_sck = 1'b0;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (o_cs_n === 1'b0) begin
                m_cs_cnt++;
                if (m_cs_first < 0) m_cs_first = k;
                m_cs_last = k;
            end
            if (o_ldac_n === 1'b0) begin
                m_ldac_cnt++;
                if (m_ldac_first < 0) m_ldac_first = k;
                m_ldac_last = k;
            end
            if (o_sck === 1'b1 && prev_sck === 1'b0) begin
                if (o_cs_n === 1'b0) begin
                    m_rises++;
                    if (m_first_rise < 0) m_first_rise = k;
                    m_frame = {m_frame[14:0], o_mosi};
                end else begin
                    m_rises_cs_high++;
                end
            end
            prev_sck = o_sck;
            if (o_done === 1'b1) begin
                m_done_cyc = k;
                if (hold) begin
                    data_in = nd; gain_1x = ng; buf_en = nb; shutdown = ns;
                end
                break;
            end
            if (!hold && inject_at == k) start = 1'b1;
            else if (!hold && inject_at + 1 == k) start = 1'b0;
            if (scramble) begin
                data_in  = 12'($urandom);
                gain_1x  = 1'($urandom);
                buf_en   = 1'($urandom);
                shutdown = 1'($urandom);
            end
        end
    endtask

    task automatic check_frame(input logic [15:0] ef);
        int h;
        h = sel ? 1 : 4;
        check("frame_word", m_frame, ef);
        check("sck_rises", m_rises, 16);
        check("sck_rises_cs_high", m_rises_cs_high, 0);
        check("first_rise_cycle", m_first_rise, h + 1);
        check("cs_low_first", m_cs_first, 1);
        check("cs_low_last", m_cs_last, 33 * h);
        check("cs_low_count", m_cs_cnt, 33 * h);
        check("ldac_low_first", m_ldac_first, 33 * h + 1);
        check("ldac_low_last", m_ldac_last, 34 * h);
        check("ldac_low_count", m_ldac_cnt, h);
        check("done_cycle", m_done_cyc, 34 * h + 1);
    endtask

    initial begin
        logic [15:0] ef;
        int gap;
        int bad_ldac;
        int bad_done;

        reset = 1'b1; start = 1'b0; sel = 1'b0;
        data_in = '0; gain_1x = 1'b0; buf_en = 1'b0; shutdown = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check("rst_cs_n", o_cs_n, 1'b1);
            check("rst_sck", o_sck, 1'b0);
            check("rst_mosi", o_mosi, 1'b0);
            check("rst_ldac_n", o_ldac_n, 1'b1);
            check("rst_busy", o_busy, 1'b0);
            check("rst_done", o_done, 1'b0);
        end
        sel = 1'b0;
        reset = 1'b0;

        // Directed word, HALF_DIV=4, first start after reset.
        @(negedge clk);
        data_in = 12'hA5C; gain_1x = 1'b1; buf_en = 1'b0; shutdown = 1'b0;
        start = 1'b1;
        run_frame(1'b0, 0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        check_frame(16'h3A5C);

        // HALF_DIV=1, full-scale code with shutdown.
        repeat (2) @(negedge clk);
        sel = 1'b1;
        data_in = 12'hFFF; gain_1x = 1'b1; buf_en = 1'b0; shutdown = 1'b1;
        start = 1'b1;
        run_frame(1'b0, 0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        check_frame(16'h2FFF);

        // Random words on both dividers.
        for (int n = 0; n < 8; n++) begin
            repeat (1 + ($urandom % 3)) @(negedge clk);
            sel      = 1'(n);
            data_in  = 12'($urandom);
            gain_1x  = 1'($urandom);
            buf_en   = 1'($urandom);
            shutdown = 1'($urandom);
            ef = exp_frame(data_in, gain_1x, buf_en, shutdown);
            start = 1'b1;
            run_frame(1'b0, 0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
            check_frame(ef);
        end

        // Back-to-back with start held high.
        repeat (2) @(negedge clk);
        sel = 1'b0;
        data_in = 12'h001; gain_1x = 1'b1; buf_en = 1'b0; shutdown = 1'b0;
        start = 1'b1;
        run_frame(1'b1, 0, 1'b1, 12'h002, 1'b1, 1'b0, 1'b0);
        check_frame(16'h3001);
        gap = m_done_cyc - m_cs_last;
        check("b2b_cs_high_gap", gap, 5);
        run_frame(1'b0, 0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        check_frame(16'h3002);

        // Start pulsed mid-SHIFT with other data is ignored.
        repeat (3) @(negedge clk);
        data_in = 12'h5A3; gain_1x = 1'b0; buf_en = 1'b1; shutdown = 1'b0;
        ef = exp_frame(data_in, gain_1x, buf_en, shutdown);
        start = 1'b1;
        run_frame(1'b0, 60, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        check_frame(ef);
        @(negedge clk);
        check("ignored_start_no_done", o_done, 1'b0);
        check("ignored_start_idle", o_busy, 1'b0);

        // Reset at cycle 50 of a frame aborts it.
        repeat (2) @(negedge clk);
        data_in = 12'($urandom); gain_1x = 1'b1; buf_en = 1'b1; shutdown = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("abort_cs_n", o_cs_n, 1'b1);
        check("abort_sck", o_sck, 1'b0);
        check("abort_busy", o_busy, 1'b0);
        check("abort_ldac_n", o_ldac_n, 1'b1);
        check("abort_done", o_done, 1'b0);
        check("abort_mosi", o_mosi, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("start_ignored_in_reset", o_busy, 1'b0);
        end
        reset = 1'b0;
        start = 1'b0;
        bad_ldac = 0;
        bad_done = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (o_ldac_n !== 1'b1) bad_ldac++;
            if (o_done !== 1'b0) bad_done++;
        end
        check("abort_no_ldac_pulse", bad_ldac, 0);
        check("abort_no_done_pulse", bad_done, 0);
        data_in = 12'h7E1; gain_1x = 1'b0; buf_en = 1'b0; shutdown = 1'b1;
        ef = exp_frame(data_in, gain_1x, buf_en, shutdown);
        start = 1'b1;
        run_frame(1'b0, 0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        check_frame(ef);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_write_spi.md
DAC_WRITE_SPI -- requirements
Module: dac_write_spi

Interface
REQ-001: The block SHALL have parameter HALF_DIV, default 4, giving the sck_out half-period in clk cycles; legal range is 1..255.
REQ-002: The block SHALL have these ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to transmit one sample; sampled only in IDLE.
- data_in  input  12  DAC code; latched when start is accepted.
- gain_1x  input  1  GA_n control bit (1 = 1x gain); latched when start is accepted.
- buf_en  input  1  VREF buffer control bit; latched when start is accepted.
- shutdown  input  1  1 = shut down DAC output; latched when start is accepted.
- sck_out  output  1  SPI serial clock to the DAC.
- mosi  output  1  SPI serial data to the DAC.
- cs_n  output  1  DAC chip select, active low.
- ldac_n  output  1  DAC latch strobe, active low.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when a transfer completes.
REQ-003: All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-004: The frame SHALL be 16 bits, MSB first: [15]=0 (channel A), [14]=buf_en, [13]=gain_1x, [12]=~shutdown, [11:0]=data_in.
REQ-005: SPI mode SHALL be 0,0: sck_out idles low, the DAC samples on the rising edge, and mosi changes only while sck_out is low.
REQ-006: The FSM SHALL have the states IDLE, SETUP, SHIFT and LATCH.
REQ-007: In IDLE, start=1 SHALL be accepted at edge 0: latch the frame, drive cs_n=0 and mosi=frame[15], set busy=1, and go to SETUP.
REQ-008: start SHALL be ignored while busy=1, with no queuing and no effect on the frame in flight.
REQ-009: SETUP SHALL last HALF_DIV cycles with sck_out=0, then go to SHIFT.
REQ-010: SHIFT SHALL send 16 bits; each bit is HALF_DIV cycles with sck_out=1 followed by HALF_DIV cycles with sck_out=0.
REQ-011: After each falling edge of sck_out except the 16th, mosi SHALL present the next frame bit in the same edge that drives sck_out low.
REQ-012: The low phase of bit 16 SHALL serve as the CS hold time; at its end the block SHALL drive cs_n=1 and ldac_n=0 and go to LATCH.
REQ-013: LATCH SHALL last HALF_DIV cycles; at its end the block SHALL drive ldac_n=1, busy=0, done=1 for one cycle, mosi=0, and go to IDLE.
REQ-014: Timing, counting cycles after acceptance edge 0, SHALL be:
- cs_n low for cycles 1..33*HALF_DIV;
- first sck_out rise at cycle HALF_DIV+1;
- ldac_n low for cycles 33*HALF_DIV+1..34*HALF_DIV;
- done high in cycle 34*HALF_DIV+1.
REQ-015: start=1 in the same cycle that done=1 SHALL be accepted, since the state is IDLE, giving back-to-back frames with cs_n high for HALF_DIV+1 cycles between them.
REQ-016: Exactly 16 rising edges of sck_out SHALL occur per frame, with none while cs_n=1.
REQ-017: The internal bit counter SHALL be 5 bits and the divider counter SHALL be 8 bits, with no wrap inside a frame.
REQ-018: HALF_DIV=1 SHALL produce a valid frame with sck_out = clk/2.

Reset
REQ-019: While reset=1, the next edge SHALL force IDLE with sck_out=0, mosi=0, cs_n=1, ldac_n=1, busy=0, done=0, and all counters and the frame register cleared.
REQ-020: Reset asserted mid-frame SHALL abort the frame with no ldac_n pulse and no done pulse; start is ignored while reset=1.
REQ-021: The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-022: HALF_DIV=4, data_in=12'hA5C, gain_1x=1, buf_en=0, shutdown=0, start pulse -> bench SPI slave model captures 16'h3A5C; cs_n low cycles 1..132; ldac_n low cycles 133..136; done in cycle 137.
REQ-023: HALF_DIV=1, data_in=12'hFFF, shutdown=1 -> frame 16'h2FFF (with gain_1x=1, buf_en=0); exactly 16 sck_out rises; done in cycle 35.
REQ-024: start held high continuously with data 12'h001 then 12'h002 -> two frames 16'h3001 and 16'h3002; cs_n high between them for HALF_DIV+1 cycles; data_in changes during frame 1 do not corrupt it.
REQ-025: start pulsed during SHIFT with different data -> ignored; captured frame unchanged; exactly one done pulse.
REQ-026: reset asserted at cycle 50 of a HALF_DIV=4 frame -> next edge cs_n=1, sck_out=0, busy=0; no ldac_n low and no done pulse; a new start afterwards completes in 137 cycles.
REQ-027: Bench assertions for all runs: mosi is stable while sck_out=1; sck_out=0 whenever cs_n=1; ldac_n=0 only while cs_n=1; done is at most one cycle wide.
